// File: rtl/soc_pkg.sv
// Shared boot-ROM defaults and arbiter type definitions.
package soc_pkg;

    localparam logic [31:0] ROM_BASE_DEFAULT = 32'h0000_0000;
    localparam int unsigned ROM_AW_DEFAULT   = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StResp
    } arb_state_e;

    typedef enum logic {
        ReqIf = 1'b0,
        ReqDb = 1'b1
    } requester_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last-grant flop only advances when a grant is issued.
module rr_arbiter2
    import soc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    requester_e last_q, last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (last_q == ReqDb) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
            if (|req) begin
                last_d = gnt[1] ? ReqDb : ReqIf;
            end
        end
    end

    // Reset to data bus so instruction fetch wins the first conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= ReqDb;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bootrom_arbiter.sv
// Shares a synchronous boot ROM between instruction-fetch and data-bus requesters,
// one outstanding read at a time, with access faults for out-of-window or misaligned reads.
module bootrom_arbiter
    import soc_pkg::*;
#(
    parameter logic [31:0] ROM_BASE = ROM_BASE_DEFAULT,
    parameter int unsigned ROM_AW   = ROM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [31:0]       if_rsp_data,
    output logic              if_rsp_err,

    input  logic              db_req_valid,
    output logic              db_req_ready,
    input  logic [31:0]       db_req_addr,
    output logic              db_rsp_valid,
    input  logic              db_rsp_ready,
    output logic [31:0]       db_rsp_data,
    output logic              db_rsp_err,

    output logic [ROM_AW-1:0] rom_ad,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    input  logic [31:0]       rom_dout
);

    arb_state_e  state_q, state_d;
    requester_e  owner_q, owner_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic [1:0]  gnt;
    logic        arb_en;
    logic [31:0] req_addr;
    logic [32:0] req_diff;
    logic        req_legal;
    logic        rsp_accept;

    // Grants are only meaningful in IDLE and never while reset is held.
    assign arb_en = (state_q == StIdle) && !reset;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   ({db_req_valid, if_req_valid}),
        .gnt   (gnt)
    );

    // 33-bit difference so an address below ROM_BASE shows up as a borrow.
    always_comb begin
        req_addr  = gnt[1] ? db_req_addr : if_req_addr;
        req_diff  = {1'b0, req_addr} - {1'b0, ROM_BASE};
        req_legal = !req_diff[32]
                    && ((req_diff[31:0] >> (ROM_AW + 2)) == 32'd0)
                    && (req_addr[1:0] == 2'b00);
    end

    assign rsp_accept = (owner_q == ReqIf) ? if_rsp_ready : db_rsp_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        data_d  = data_q;
        err_d   = err_q;
        rom_ce  = 1'b0;
        rom_ad  = '0;
        case (state_q)
            StIdle: begin
                if (|gnt) begin
                    owner_d = gnt[1] ? ReqDb : ReqIf;
                    if (req_legal) begin
                        rom_ce  = 1'b1;
                        rom_ad  = ROM_AW'(req_diff[31:0] >> 2);
                        state_d = StRead;
                    end else begin
                        data_d  = 32'd0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StRead: begin
                data_d  = rom_dout;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_accept) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= ReqIf;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign if_req_ready = gnt[0];
    assign db_req_ready = gnt[1];
    assign if_rsp_valid = (state_q == StResp) && (owner_q == ReqIf);
    assign db_rsp_valid = (state_q == StResp) && (owner_q == ReqDb);
    assign if_rsp_data  = data_q;
    assign db_rsp_data  = data_q;
    assign if_rsp_err   = err_q;
    assign db_rsp_err   = err_q;

    assign rom_oce   = 1'b1;
    assign rom_reset = reset;

endmodule

// File: doc/bootrom_arbiter.md
BOOTROM_ARBITER -- requirements
Module: bootrom_arbiter

Interface
REQ-001 SHALL have parameter ROM_BASE, default 32'h0000_0000, byte base address of the boot ROM window.
REQ-002 SHALL have parameter ROM_AW, default 10, ROM word-address width; window size is 4*2^ROM_AW bytes.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port if_req_valid  input  1  instruction-fetch requester presents a read.
REQ-006 SHALL have port if_req_ready  output  1  instruction-fetch request accepted this cycle.
REQ-007 SHALL have port if_req_addr  input  32  instruction-fetch byte address.
REQ-008 SHALL have port if_rsp_valid  output  1  instruction-fetch response available.
REQ-009 SHALL have port if_rsp_ready  input  1  instruction-fetch requester consumes the response.
REQ-010 SHALL have port if_rsp_data  output  32  instruction-fetch read data.
REQ-011 SHALL have port if_rsp_err  output  1  instruction-fetch access fault.
REQ-012 SHALL have ports db_req_valid, db_req_ready, db_req_addr, db_rsp_valid, db_rsp_ready, db_rsp_data and db_rsp_err; directions, widths and meanings match the if_ ports, applied to the data-bus requester.
REQ-013 SHALL have port rom_ad  output  ROM_AW  ROM word address.
REQ-014 SHALL have port rom_ce  output  1  ROM clock enable; asserted for exactly one cycle per ROM read.
REQ-015 SHALL have port rom_oce  output  1  ROM output enable; tied to 1.
REQ-016 SHALL have port rom_reset  output  1  ROM output reset; driven equal to reset.
REQ-017 SHALL have port rom_dout  input  32  ROM read data, valid the cycle after rom_ce.

Function
REQ-018 SHALL implement states IDLE, READ and RESP.
REQ-019 SHALL accept at most one request, and only in IDLE; req_ready is 0 in READ and RESP.
REQ-020 SHALL grant the sole requester when only one req_valid is high.
REQ-021 SHALL grant the requester not granted last when both req_valid are high in IDLE (round-robin); the winner's req_ready is 1 and the loser's is 0.
REQ-022 SHALL treat an address as legal when ROM_BASE <= addr < ROM_BASE + 4*2^ROM_AW and addr[1:0] == 0.
REQ-023 On a legal accept at cycle T, SHALL drive rom_ce = 1 and rom_ad = (addr - ROM_BASE)[ROM_AW+1:2] in cycle T, then go to READ.
REQ-024 In READ at T+1, SHALL capture rom_dout into the response register, set err = 0 and go to RESP; rsp_valid is first seen at T+2.
REQ-025 On an illegal accept at T, SHALL keep rom_ce = 0, set the response data to 0 and err = 1, and go directly to RESP; rsp_valid is first seen at T+1.
REQ-026 In RESP, SHALL assert rsp_valid only to the owning requester, and hold data and err stable until that requester's rsp_ready is 1.
REQ-027 On rsp_valid && rsp_ready, SHALL return to IDLE; a new accept is possible in the following cycle at the earliest.
REQ-028 SHALL impose no obligation on a requester that deasserts req_valid before being accepted.
REQ-029 SHALL keep rom_ce = 0 in every cycle other than the legal-accept cycle.

Reset
REQ-030 While reset is high, SHALL hold: state = IDLE, all req_ready/rsp_valid/rsp_err = 0, rsp_data = 0, rom_ce = 0, last-grant = data bus (so instruction fetch wins the first conflict).
REQ-031 Reset asserted mid-transaction SHALL discard the transaction with no response delivered.

Structure
REQ-032 SHALL place ROM_BASE, ROM_AW defaults and the state enum in shared package soc_pkg.
REQ-033 SHALL implement the two-way round-robin grant and last-grant flop in sub-module rr_arbiter2.

Verification
REQ-034 Single fetch: if_req_addr = 0x0 with ROM word0 = 0x0001_1117 -> if_rsp_valid at T+2, data 0x0001_1117, err 0.
REQ-035 Conflict: both requesters valid at addr 0x0 / 0x4 right after reset -> if served first (0x0001_1117), then db served (0xD000_0113).
REQ-036 Misaligned: db_req_addr = 0x2 -> db_rsp_valid at T+1, err 1, data 0, rom_ce never high.
REQ-037 Out of range: if_req_addr = 0x1000 -> err 1, rom_ce 0.
REQ-038 Backpressure: hold if_rsp_ready = 0 for 5 cycles -> data stable, db request not accepted until the response is consumed.
REQ-039 Reset in READ -> no rsp_valid; the next fetch completes normally.
